// File: rtl/riscv_icache_refill_array_if.sv
// riscv_icache_refill_array_if: read, refill-beat and status signals of the icache line array
interface riscv_icache_refill_array_if #(
  parameter int INDEX      = 12,
  parameter int DWIDTH     = 128,
  parameter int BEAT_WIDTH = 32
);
  logic                  rden;
  logic [INDEX-1:0]      index;
  logic                  flush;
  logic                  refill_start;
  logic [INDEX-1:0]      refill_index;
  logic                  beat_valid;
  logic [BEAT_WIDTH-1:0] beat_data;
  logic                  beat_ready;
  logic                  refill_done;
  logic                  busy;
  logic [DWIDTH-1:0]     data_out;
  logic [DWIDTH-1:0]     data_out_next;
  logic                  hit;
  logic                  hit_next;
  modport master (
    output rden, index, flush, refill_start, refill_index, beat_valid, beat_data,
    input  beat_ready, refill_done, busy, data_out, data_out_next, hit, hit_next
  );
  modport slave (
    input  rden, index, flush, refill_start, refill_index, beat_valid, beat_data,
    output beat_ready, refill_done, busy, data_out, data_out_next, hit, hit_next
  );
endinterface

// File: rtl/riscv_icache_refill_array.sv
// riscv_icache_refill_array: icache data/valid array with beat-wise line refill and dual-line read
module riscv_icache_refill_array #(
  parameter int INDEX      = 12,
  parameter int DWIDTH     = 128,
  parameter int BEAT_WIDTH = 32
) (
  input logic                          clk,
  input logic                          rst_n,
  riscv_icache_refill_array_if.slave   bus
);
  localparam int DEPTH = 2 ** INDEX;
  localparam int BEATS = DWIDTH / BEAT_WIDTH;
  localparam int CW    = $clog2(BEATS);
  typedef enum logic [1:0] {IDLE, FILL, COMMIT} state_e;
  state_e              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [INDEX-1:0]    line_q, line_d, index_next;
  logic [DWIDTH-1:0]   line_buf_q, line_buf_d;
  logic [DEPTH-1:0]    valid_q, valid_d;
  logic [DWIDTH-1:0]   data_out_q, data_out_d, data_out_next_q, data_out_next_d;
  logic                hit_q, hit_d, hit_next_q, hit_next_d, we;
  logic [DWIDTH-1:0]   mem [DEPTH];
  assign bus.beat_ready    = state_q == FILL;
  assign bus.refill_done   = state_q == COMMIT && !bus.flush;
  assign bus.busy          = state_q != IDLE;
  assign bus.data_out      = data_out_q;
  assign bus.data_out_next = data_out_next_q;
  assign bus.hit           = hit_q;
  assign bus.hit_next      = hit_next_q;
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    line_d     = line_q;
    line_buf_d = line_buf_q;
    valid_d    = valid_q;
    we         = 1'b0;
    if (state_q == IDLE && bus.refill_start) begin
      state_d                    = FILL;
      line_d                     = bus.refill_index;
      cnt_d                      = '0;
      valid_d[bus.refill_index]  = 1'b0;
    end
    if (state_q == FILL && bus.beat_valid) begin
      line_buf_d[cnt_q*BEAT_WIDTH +: BEAT_WIDTH] = bus.beat_data;
      cnt_d   = cnt_q + 1'b1;
      state_d = cnt_q == CW'(BEATS - 1) ? COMMIT : FILL;
    end
    if (state_q == COMMIT) begin
      we              = 1'b1;
      valid_d[line_q] = 1'b1;
      state_d         = IDLE;
    end
    // flush overrides every transition above, including a pending commit
    if (bus.flush) begin
      state_d = IDLE;
      valid_d = '0;
      we      = 1'b0;
    end
    index_next      = bus.index + 1'b1;
    data_out_d      = data_out_q;
    data_out_next_d = data_out_next_q;
    hit_d           = hit_q;
    hit_next_d      = hit_next_q;
    if (bus.rden) begin
      data_out_d      = (we && bus.index == line_q) ? line_buf_q : mem[bus.index];
      data_out_next_d = (we && index_next == line_q) ? line_buf_q : mem[index_next];
      hit_d           = !bus.flush && ((we && bus.index == line_q) || valid_q[bus.index]);
      hit_next_d      = !bus.flush && ((we && index_next == line_q) || valid_q[index_next]);
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      cnt_q           <= '0;
      line_q          <= '0;
      line_buf_q      <= '0;
      valid_q         <= '0;
      data_out_q      <= '0;
      data_out_next_q <= '0;
      hit_q           <= 1'b0;
      hit_next_q      <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      line_q          <= line_d;
      line_buf_q      <= line_buf_d;
      valid_q         <= valid_d;
      data_out_q      <= data_out_d;
      data_out_next_q <= data_out_next_d;
      hit_q           <= hit_d;
      hit_next_q      <= hit_next_d;
    end
  end
  always_ff @(posedge clk) begin
    if (we) mem[line_q] <= line_buf_q;
  end
endmodule

// File: tb/tb_riscv_icache_refill_array.sv
// tb_riscv_icache_refill_array: directed table-driven checks plus refill/flush/reset sequences
module tb_riscv_icache_refill_array;
  localparam int IW = 12, DW = 128, BW = 32;
  localparam logic [DW-1:0] L5  = 128'h44444444_33333333_22222222_11111111;
  localparam logic [DW-1:0] L0  = 128'hA3A3A3A3_A2A2A2A2_A1A1A1A1_A0A0A0A0;
  localparam logic [DW-1:0] LF  = 128'hF3F3F3F3_F2F2F2F2_F1F1F1F1_F0F0F0F0;
  localparam logic [DW-1:0] L7  = 128'h77770003_77770002_77770001_77770000;
  localparam logic [DW-1:0] L7B = 128'h7B7B0003_7B7B0002_7B7B0001_7B7B0000;
  localparam logic [DW-1:0] L12 = 128'hC0DE0003_C0DE0002_C0DE0001_C0DE0000;
  localparam logic [DW-1:0] L9  = 128'h99990003_99990002_99990001_99990000;
  typedef struct {
    logic          rden;
    logic [IW-1:0] idx;
    logic          hit;
    logic          hn;
    bit            cd;
    logic [DW-1:0] d;
    bit            cn;
    logic [DW-1:0] dn;
  } vec_t;
  logic clk = 1'b0, rst_n = 1'b0;
  int pass_cnt = 0, total = 0, done_cnt = 0;
  vec_t vecs [6];
  always #5 clk = ~clk;
  riscv_icache_refill_array_if #(.INDEX(IW), .DWIDTH(DW), .BEAT_WIDTH(BW)) bus ();
  riscv_icache_refill_array #(.INDEX(IW), .DWIDTH(DW), .BEAT_WIDTH(BW)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );
  always @(negedge clk) if (bus.refill_done === 1'b1) done_cnt++;
  task automatic chk(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    total++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic refill(input logic [IW-1:0] li, input logic [DW-1:0] line, input bit gap,
                        input bit rd, input logic [IW-1:0] ri);
    int d0;
    d0 = done_cnt;
    bus.refill_start = 1'b1;
    bus.refill_index = li;
    tick();
    bus.refill_start = 1'b0;
    chk("fill_busy", bus.busy, 1);
    chk("fill_ready", bus.beat_ready, 1);
    for (int k = 0; k < 4; k++) begin
      if (gap && k == 2) begin
        bus.beat_valid = 1'b0;
        tick();
      end
      bus.beat_valid = 1'b1;
      bus.beat_data  = line[k*BW +: BW];
      tick();
    end
    bus.beat_valid = 1'b0;
    chk("commit_done", bus.refill_done, 1);
    chk("commit_ready", bus.beat_ready, 0);
    bus.rden  = rd;
    bus.index = ri;
    tick();
    bus.rden = 1'b0;
    chk("idle_busy", bus.busy, 0);
    chk("done_pulses", done_cnt - d0, 1);
  endtask
  initial begin
    int d0;
    bus.rden = 0; bus.index = '0; bus.flush = 0; bus.refill_start = 0;
    bus.refill_index = '0; bus.beat_valid = 0; bus.beat_data = '0;
    vecs[0] = '{1'b1, 12'd5,    1'b1, 1'b0, 1'b1, L5, 1'b0, '0};
    vecs[1] = '{1'b1, 12'd4,    1'b0, 1'b1, 1'b0, '0, 1'b1, L5};
    vecs[2] = '{1'b1, 12'd4095, 1'b1, 1'b1, 1'b1, LF, 1'b1, L0};
    vecs[3] = '{1'b1, 12'd0,    1'b1, 1'b0, 1'b1, L0, 1'b0, '0};
    vecs[4] = '{1'b0, 12'd5,    1'b1, 1'b0, 1'b1, L0, 1'b0, '0};
    vecs[5] = '{1'b1, 12'd4094, 1'b0, 1'b1, 1'b0, '0, 1'b1, LF};
    #2;
    chk("rst_busy", bus.busy, 0);
    chk("rst_ready", bus.beat_ready, 0);
    chk("rst_done", bus.refill_done, 0);
    chk("rst_hit", bus.hit, 0);
    chk("rst_hit_next", bus.hit_next, 0);
    chk("rst_data", bus.data_out, 0);
    chk("rst_data_next", bus.data_out_next, 0);
    tick();
    rst_n = 1'b1;
    bus.rden = 1'b1; bus.index = 12'd5;
    tick();
    bus.rden = 1'b0;
    chk("cold_hit", bus.hit, 0);
    chk("cold_hit_next", bus.hit_next, 0);
    chk("cold_busy", bus.busy, 0);
    refill(12'd5, L5, 1'b1, 1'b0, '0);
    refill(12'd0, L0, 1'b0, 1'b0, '0);
    refill(12'd4095, LF, 1'b0, 1'b0, '0);
    for (int i = 0; i < 6; i++) begin
      bus.rden  = vecs[i].rden;
      bus.index = vecs[i].idx;
      tick();
      bus.rden = 1'b0;
      chk($sformatf("vec%0d_hit", i), bus.hit, vecs[i].hit);
      chk($sformatf("vec%0d_hit_next", i), bus.hit_next, vecs[i].hn);
      if (vecs[i].cd) chk($sformatf("vec%0d_data", i), bus.data_out, vecs[i].d);
      if (vecs[i].cn) chk($sformatf("vec%0d_data_next", i), bus.data_out_next, vecs[i].dn);
    end
    refill(12'd7, L7, 1'b0, 1'b1, 12'd7);
    chk("bypass_data", bus.data_out, L7);
    chk("bypass_hit", bus.hit, 1);
    refill(12'd7, L7B, 1'b0, 1'b1, 12'd6);
    chk("bypass_hit_next", bus.hit_next, 1);
    chk("bypass_data_next", bus.data_out_next, L7B);
    d0 = done_cnt;
    bus.refill_start = 1'b1; bus.refill_index = 12'd12;
    tick();
    bus.refill_start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      bus.beat_valid   = 1'b1;
      bus.beat_data    = L12[k*BW +: BW];
      bus.refill_start = k == 1;
      bus.refill_index = 12'd13;
      tick();
    end
    bus.beat_valid = 1'b0; bus.refill_start = 1'b0;
    tick();
    bus.rden = 1'b1; bus.index = 12'd12;
    tick();
    bus.rden = 1'b0;
    chk("restart_ignored_hit", bus.hit, 1);
    chk("restart_ignored_data", bus.data_out, L12);
    chk("restart_ignored_hit_next", bus.hit_next, 0);
    chk("restart_ignored_done", done_cnt - d0, 1);
    d0 = done_cnt;
    bus.refill_start = 1'b1; bus.refill_index = 12'd10;
    tick();
    bus.refill_start = 1'b0;
    for (int k = 0; k < 2; k++) begin
      bus.beat_valid = 1'b1;
      bus.beat_data  = 32'hDEAD0000 + k;
      tick();
    end
    bus.beat_valid = 1'b0;
    bus.flush = 1'b1; bus.rden = 1'b1; bus.index = 12'd12;
    tick();
    bus.flush = 1'b0; bus.rden = 1'b0;
    chk("flush_busy", bus.busy, 0);
    chk("flush_ready", bus.beat_ready, 0);
    chk("flush_read_hit", bus.hit, 0);
    chk("flush_read_hit_next", bus.hit_next, 0);
    bus.rden = 1'b1; bus.index = 12'd10;
    tick();
    bus.rden = 1'b0;
    tick();
    chk("flush_line_hit", bus.hit, 0);
    chk("flush_no_done", done_cnt - d0, 0);
    refill(12'd9, L9, 1'b0, 1'b0, '0);
    bus.rden = 1'b1; bus.index = 12'd9;
    tick();
    bus.rden = 1'b0;
    chk("pre_rst_hit", bus.hit, 1);
    bus.refill_start = 1'b1; bus.refill_index = 12'd9;
    tick();
    bus.refill_start = 1'b0;
    bus.beat_valid = 1'b1; bus.beat_data = 32'h55555555;
    tick();
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", bus.busy, 0);
    chk("midrst_ready", bus.beat_ready, 0);
    chk("midrst_hit", bus.hit, 0);
    chk("midrst_data", bus.data_out, 0);
    bus.beat_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    bus.rden = 1'b1; bus.index = 12'd9;
    tick();
    bus.rden = 1'b0;
    chk("post_rst_hit", bus.hit, 0);
    chk("post_rst_array_kept", bus.data_out, L9);
    chk("post_rst_busy", bus.busy, 0);
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end
endmodule
